updi_tx_serializer: RTL and testbench

- Downstream stage of the UPDI instruction queue handler; consumes the byte FIFO it fills (SYNCH 0x55, opcode, data).
- Pops one byte at a time and serialises it onto the one-wire UPDI line as a UART frame: 1 start bit, 8 data bits LSB first, even parity, 2 stop bits.
- Drives a line-enable so the pad can release the shared wire (pull-up idle) when not transmitting.

---
 rtl/updi_tx_serializer.sv | 132 +++++++++++++
 tb/tb_updi_tx_serializer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_tx_serializer.sv
// UPDI one-wire transmitter: pops bytes from the instruction FIFO and sends 8E2 UART frames.
// Optional line BREAK generation is enabled by defining UPDI_TX_BREAK_EN.
module updi_tx_serializer #(
  parameter int CLK_DIV  = 16,
  parameter int CNT_BITS = $clog2(CLK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       tx_en,
  output logic       busy,
`ifdef UPDI_TX_BREAK_EN
  input  logic       send_break,
  output logic       break_done,
`endif
  output logic       byte_sent
);

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, PARITY, STOP
`ifdef UPDI_TX_BREAK_EN
    , BREAK
`endif
  } state_t;

  state_t              state, state_next;
  logic [CNT_BITS-1:0] cnt;
  logic [4:0]          idx;
  logic [7:0]          shift_reg;
  logic                parity_reg;
  logic                bit_end;
  logic                timed;

  assign bit_end = (cnt == CNT_BITS'(CLK_DIV - 1));

  // States whose duration is measured in bit times
  always_comb begin
    timed = 1'b0;
    case (state)
      START, DATA, PARITY, STOP: timed = 1'b1;
`ifdef UPDI_TX_BREAK_EN
      BREAK:                     timed = 1'b1;
`endif
      default:                   timed = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (timed && !bit_end)
        cnt <= cnt + CNT_BITS'(1);
      else
        cnt <= '0;
      // idx counts bit times within the current state and restarts on every state change
      if (state_next != state)
        idx <= '0;
      else if (timed && bit_end)
        idx <= idx + 5'd1;
      if (state == LOAD) begin
        shift_reg  <= fifo_data;
        parity_reg <= ^fifo_data;
      end else if (state == DATA && bit_end) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
`ifdef UPDI_TX_BREAK_EN
        if (send_break)
          state_next = BREAK;
        else
`endif
        if (!fifo_empty)
          state_next = POP;
      end
      POP:    state_next = LOAD;
      LOAD:   state_next = START;
      START:  if (bit_end) state_next = DATA;
      DATA:   if (bit_end && idx == 5'd7) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end && idx == 5'd1) state_next = fifo_empty ? IDLE : POP;
`ifdef UPDI_TX_BREAK_EN
      BREAK:  if (bit_end && idx == 5'd25) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    tx_en      = 1'b0;
    fifo_rd_en = 1'b0;
    byte_sent  = 1'b0;
    busy       = (state != IDLE);
`ifdef UPDI_TX_BREAK_EN
    break_done = 1'b0;
`endif
    case (state)
      POP:    fifo_rd_en = 1'b1;
      START:  begin tx = 1'b0;         tx_en = 1'b1; end
      DATA:   begin tx = shift_reg[0]; tx_en = 1'b1; end
      PARITY: begin tx = parity_reg;   tx_en = 1'b1; end
      STOP: begin
        tx_en     = 1'b1;
        byte_sent = bit_end && idx == 5'd1;
      end
`ifdef UPDI_TX_BREAK_EN
      BREAK: begin
        tx         = (idx >= 5'd24);
        tx_en      = 1'b1;
        break_done = bit_end && idx == 5'd25;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_updi_tx_serializer.sv
// Scoreboard bench for updi_tx_serializer: directed bytes with hand-computed 12-bit frames.
`timescale 1ns/1ps
module tb_updi_tx_serializer;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 12 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty, fifo_rd_en, tx, tx_en, busy, byte_sent;
  logic       bd_sig;
`ifdef UPDI_TX_BREAK_EN
  logic       send_break = 1'b0;
  logic       break_done;
  assign bd_sig = break_done;
`else
  assign bd_sig = 1'b0;
`endif

  always #5 clk = ~clk;

  updi_tx_serializer #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .tx_en      (tx_en),
    .busy       (busy),
`ifdef UPDI_TX_BREAK_EN
    .send_break (send_break),
    .break_done (break_done),
`endif
    .byte_sent  (byte_sent)
  );

  // Small FIFO model: written between edges, read data valid the cycle after the pop
  logic [7:0] mem [0:15];
  logic [3:0] wp = '0, rp = '0;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) if (fifo_rd_en) begin
    fifo_data <= mem[rp];
    rp        <= rp + 4'd1;
  end

  typedef struct { bit brk; logic [11:0] frame; int gap; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int rd_cnt = 0, bs_total = 0, bd_total = 0;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: captures every tx_en burst and compares it with the scoreboard head
  logic [127:0] samp;
  int  pos = 0, low_run = 0, bs_pos = -1, bs_n = 0, bd_pos = -1, bd_n = 0;
  logic prev_en = 1'b0;

  task automatic finalize();
    exp_t e;
    logic [11:0] got;
    int bad;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    bad = 0;
    if (e.brk) begin
      check("break_len", pos, 26 * CLK_DIV);
      for (int i = 0; i < 26 * CLK_DIV; i++)
        if (samp[i] !== (i >= 24 * CLK_DIV)) bad++;
      check("break_wave", bad, 0);
      check("break_done_pos", (bd_n == 1) ? bd_pos : -1, 26 * CLK_DIV - 1);
      check("break_byte_sent", bs_n, 0);
    end else begin
      check("frame_len", pos, FRAME);
      got = '0;
      for (int b = 0; b < 12; b++) begin
        got[b] = samp[b * CLK_DIV];
        for (int k = 1; k < CLK_DIV; k++)
          if (samp[b * CLK_DIV + k] !== got[b]) bad++;
      end
      check("frame_bits", int'(got), int'(e.frame));
      check("bit_stable", bad, 0);
      check("byte_sent_pos", (bs_n == 1) ? bs_pos : -1, FRAME - 1);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (pos > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
      pos = 0; prev_en = 1'b0; low_run = 0;
    end else begin
      if (fifo_rd_en) rd_cnt++;
      if (byte_sent)  bs_total++;
      if (bd_sig)     bd_total++;
      if (tx_en && !prev_en) begin
        if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
        else if (exp_q[0].gap >= 0) check("frame_gap", low_run, exp_q[0].gap);
        pos = 0; bs_n = 0; bd_n = 0; bs_pos = -1; bd_pos = -1;
      end
      if (tx_en) begin
        if (pos < 128) samp[pos] = tx;
        if (byte_sent) begin bs_n++; bs_pos = pos; end
        if (bd_sig)    begin bd_n++; bd_pos = pos; end
        pos++;
      end
      if (!tx_en && prev_en) begin
        finalize();
        pos = 0;
      end
      low_run = tx_en ? 0 : low_run + 1;
      prev_en = tx_en;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 4'd1;
  endtask

  task automatic expect_frame(input bit brk, input logic [11:0] f, input int gap);
    exp_t e;
    e.brk = brk; e.frame = f; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_sent(input int target, input int budget);
    for (int i = 0; i < budget && bs_total < target; i++) tick();
    check("byte_sent_count", bs_total, target);
  endtask

  task automatic idle_window(input string name, input int cycles);
    int viol = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx !== 1'b1 || tx_en !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) viol++;
    end
    check(name, viol, 0);
  endtask

  int bs0, rd0, busy_low, waited;

  initial begin
    repeat (3) tick();
    check("rst_tx", int'(tx), 1);
    check("rst_tx_en", int'(tx_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_byte_sent", int'(byte_sent), 0);
    rst = 1'b0;
    tick();

    // 0x55: even parity 0; also checks POP/LOAD/START latency
    bs0 = bs_total; rd0 = rd_cnt;
    expect_frame(0, 12'hCAA, -1);
    push(8'h55);
    tick();
    check("lat_pop_rd_en", int'(fifo_rd_en), 1);
    check("lat_pop_busy", int'(busy), 1);
    tick();
    check("lat_load_rd_en", int'(fifo_rd_en), 0);
    check("lat_load_tx_en", int'(tx_en), 0);
    tick();
    check("lat_start_tx", int'(tx), 0);
    check("lat_start_tx_en", int'(tx_en), 1);
    wait_sent(bs0 + 1, 100);
    check("rd_pulses_55", rd_cnt - rd0, 1);
    repeat (5) tick();

    // 0xE5: five ones so parity bit is 1
    bs0 = bs_total;
    expect_frame(0, 12'hFCA, -1);
    push(8'hE5);
    wait_sent(bs0 + 1, 100);
    repeat (5) tick();

    // three queued bytes go out back-to-back with 2-cycle gaps
    bs0 = bs_total; rd0 = rd_cnt; busy_low = 0;
    expect_frame(0, 12'hCAA, -1);
    expect_frame(0, 12'hE8A, 2);
    expect_frame(0, 12'hC24, 2);
    push(8'h55); push(8'h45); push(8'h12);
    tick();
    for (int i = 0; i < 3 * FRAME + 40; i++) begin
      if (!busy) busy_low++;
      if (bs_total >= bs0 + 3) break;
      tick();
    end
    check("busy_b2b", busy_low, 0);
    check("byte_sent_count", bs_total, bs0 + 3);
    check("rd_pulses_b2b", rd_cnt - rd0, 3);

    // empty FIFO stays idle
    rd0 = rd_cnt;
    idle_window("idle_100", 100);
    check("idle_no_rd", rd_cnt - rd0, 0);

    // reset in the middle of data bit 3
    expect_frame(0, 12'hCAA, -1);
    push(8'h55);
    waited = 0;
    while (!tx_en && waited < 10) begin tick(); waited++; end
    check("mid_frame_started", int'(tx_en), 1);
    repeat (17) tick();
    check("mid_data_bit3", int'(tx), 0);
    rst = 1'b1;
    #1;
    check("async_rst_tx", int'(tx), 1);
    check("async_rst_tx_en", int'(tx_en), 0);
    check("async_rst_busy", int'(busy), 0);
    tick(); tick();
    rst = 1'b0;
    rd0 = rd_cnt;
    idle_window("idle_after_rst", 30);
    check("no_rd_after_rst", rd_cnt - rd0, 0);

`ifdef UPDI_TX_BREAK_EN
    // break wins over a non-empty FIFO; the byte follows after IDLE/POP/LOAD
    bs0 = bs_total; rd0 = rd_cnt;
    expect_frame(1, 12'h000, -1);
    expect_frame(0, 12'hCAA, 3);
    push(8'h55);
    send_break = 1'b1;
    tick();
    send_break = 1'b0;
    check("break_no_pop", int'(fifo_rd_en), 0);
    wait_sent(bs0 + 1, 300);
    check("break_done_count", bd_total, 1);
    check("rd_pulses_break", rd_cnt - rd0, 1);
`endif

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
